// File: rtl/ibuf_queue.sv
// Instruction buffer between predecode and decode: compacts sparse predecode
// lanes into a circular queue and hands the oldest entries to decode in order.
module ibuf_queue #(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned IN_WIDTH   = 8,
   parameter int unsigned OUT_WIDTH  = 4,
   parameter int unsigned INST_WIDTH = 32,
   parameter int unsigned FSQ_W      = 6
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [IN_WIDTH-1:0]                   in_en,
   input  logic [$clog2(IN_WIDTH):0]             in_num,
   input  logic [IN_WIDTH*INST_WIDTH-1:0]        in_inst,
   input  logic [FSQ_W-1:0]                      in_fsqIdx,
   output logic                                  full,
   output logic [OUT_WIDTH-1:0]                  out_en,
   output logic [OUT_WIDTH*INST_WIDTH-1:0]       out_inst,
   output logic [OUT_WIDTH*FSQ_W-1:0]            out_fsqIdx,
   output logic [OUT_WIDTH*$clog2(IN_WIDTH)-1:0] out_offset,
   input  logic                                  stall,
   input  logic                                  flush,
   output logic [$clog2(DEPTH):0]                count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OFF_W = $clog2(IN_WIDTH);
   localparam int unsigned NUM_W = OFF_W + 1;

   typedef struct packed {
      logic [INST_WIDTH-1:0] inst;
      logic [FSQ_W-1:0]      fsq_idx;
      logic [OFF_W-1:0]      offset;
   } entry_t;

   entry_t mem [DEPTH];

   // Pointers carry a wrap bit so tail - head always equals the occupancy.
   logic [CNT_W-1:0] head;
   logic [CNT_W-1:0] tail;
   logic [PTR_W-1:0] head_idx;
   logic [PTR_W-1:0] tail_idx;

   logic             enq;
   logic [CNT_W-1:0] enq_num;
   logic [CNT_W-1:0] deq_num;
   logic [CNT_W-1:0] free_slots;
   logic [NUM_W-1:0] lane_pos [IN_WIDTH];
   logic [NUM_W-1:0] in_pop;

   assign head_idx = head[PTR_W-1:0];
   assign tail_idx = tail[PTR_W-1:0];

   // Slot of each enabled lane relative to tail = number of enabled lanes below it.
   always_comb begin
      in_pop = '0;
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
         lane_pos[i] = in_pop;
         in_pop      = in_pop + NUM_W'(in_en[i]);
      end
   end

   always_comb begin
      free_slots = CNT_W'(DEPTH) - count;
      full       = free_slots < CNT_W'(IN_WIDTH);
      enq        = (|in_en) && !full && !flush;
      enq_num    = enq ? CNT_W'(in_num) : '0;
      if (stall)
         deq_num = '0;
      else if (count < CNT_W'(OUT_WIDTH))
         deq_num = count;
      else
         deq_num = CNT_W'(OUT_WIDTH);
   end

   // Read ports: lane i always shows entry head+i, gated by occupancy and stall.
   always_comb begin
      out_en     = '0;
      out_inst   = '0;
      out_fsqIdx = '0;
      out_offset = '0;
      for (int i = 0; i < int'(OUT_WIDTH); i++) begin
         out_en[i]                              = !stall && (count > CNT_W'(i));
         out_inst[i*INST_WIDTH +: INST_WIDTH]   = mem[PTR_W'(head_idx + PTR_W'(i))].inst;
         out_fsqIdx[i*FSQ_W +: FSQ_W]           = mem[PTR_W'(head_idx + PTR_W'(i))].fsq_idx;
         out_offset[i*OFF_W +: OFF_W]           = mem[PTR_W'(head_idx + PTR_W'(i))].offset;
      end
   end

   // Storage holds no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (enq) begin
         for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (in_en[i]) begin
               mem[PTR_W'(tail_idx + PTR_W'(lane_pos[i]))] <= '{
                  inst:    in_inst[i*INST_WIDTH +: INST_WIDTH],
                  fsq_idx: in_fsqIdx,
                  offset:  OFF_W'(i)
               };
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_num;
         tail  <= tail + enq_num;
         count <= count + enq_num - deq_num;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (in_num == in_pop);
         assert (count <= CNT_W'(DEPTH));
         assert (!(enq && full));
         assert (CNT_W'(tail - head) == count);
      end
   end

endmodule

// File: tb/tb_ibuf_queue.sv
// Scoreboard bench for ibuf_queue: a reference FIFO of expected entries is
// filled on accepted writes and drained as decode consumes output lanes.
module tb_ibuf_queue;

   localparam int DEPTH      = 32;
   localparam int IN_WIDTH   = 8;
   localparam int OUT_WIDTH  = 4;
   localparam int INST_WIDTH = 32;
   localparam int FSQ_W      = 6;
   localparam int OFF_W      = 3;
   localparam int CNT_W      = 6;

   typedef struct {
      logic [INST_WIDTH-1:0] inst;
      logic [FSQ_W-1:0]      fsq;
      logic [OFF_W-1:0]      off;
   } exp_t;

   logic                            clk;
   logic                            rst;
   logic [IN_WIDTH-1:0]             in_en;
   logic [OFF_W:0]                  in_num;
   logic [IN_WIDTH*INST_WIDTH-1:0]  in_inst;
   logic [FSQ_W-1:0]                in_fsqIdx;
   logic                            full;
   logic [OUT_WIDTH-1:0]            out_en;
   logic [OUT_WIDTH*INST_WIDTH-1:0] out_inst;
   logic [OUT_WIDTH*FSQ_W-1:0]      out_fsqIdx;
   logic [OUT_WIDTH*OFF_W-1:0]      out_offset;
   logic                            stall;
   logic                            flush;
   logic [CNT_W-1:0]                count;

   exp_t sbq[$];
   int   vectors  = 0;
   int   errors   = 0;
   bit   checking = 0;

   ibuf_queue #(
      .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
      .INST_WIDTH(INST_WIDTH), .FSQ_W(FSQ_W)
   ) dut (
      .clk(clk), .rst(rst), .in_en(in_en), .in_num(in_num), .in_inst(in_inst),
      .in_fsqIdx(in_fsqIdx), .full(full), .out_en(out_en), .out_inst(out_inst),
      .out_fsqIdx(out_fsqIdx), .out_offset(out_offset), .stall(stall),
      .flush(flush), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_write(input logic [IN_WIDTH-1:0] mask, input logic [31:0] base,
                              input logic [FSQ_W-1:0] fsq);
      in_en     = mask;
      in_num    = 4'($countones(mask));
      in_fsqIdx = fsq;
      for (int i = 0; i < IN_WIDTH; i++)
         in_inst[i*INST_WIDTH +: INST_WIDTH] = base + 32'(i);
   endtask

   task automatic drive_idle();
      in_en  = '0;
      in_num = '0;
   endtask

   // Compare outputs against the reference FIFO before the edge, then advance it.
   task automatic apply();
      int   deq;
      bit   mfull;
      bit   exp_en;
      exp_t e;
      @(negedge clk);
      mfull = (DEPTH - sbq.size()) < IN_WIDTH;
      if (checking) begin
         vectors++;
         if (count !== CNT_W'(sbq.size())) begin
            errors++;
            $display("FAIL sb_count: got %0d expected %0d", count, sbq.size());
         end
         vectors++;
         if (full !== mfull) begin
            errors++;
            $display("FAIL sb_full: got %0b expected %0b", full, mfull);
         end
         for (int i = 0; i < OUT_WIDTH; i++) begin
            exp_en = !stall && (i < sbq.size());
            vectors++;
            if (out_en[i] !== exp_en) begin
               errors++;
               $display("FAIL sb_out_en[%0d]: got %0b expected %0b", i, out_en[i], exp_en);
            end
            if (exp_en) begin
               vectors++;
               if (out_inst[i*INST_WIDTH +: INST_WIDTH] !== sbq[i].inst ||
                   out_fsqIdx[i*FSQ_W +: FSQ_W] !== sbq[i].fsq ||
                   out_offset[i*OFF_W +: OFF_W] !== sbq[i].off) begin
                  errors++;
                  $display("FAIL sb_lane[%0d]: got inst=%h fsq=%0d off=%0d expected inst=%h fsq=%0d off=%0d",
                           i, out_inst[i*INST_WIDTH +: INST_WIDTH], out_fsqIdx[i*FSQ_W +: FSQ_W],
                           out_offset[i*OFF_W +: OFF_W], sbq[i].inst, sbq[i].fsq, sbq[i].off);
               end
            end
         end
      end
      if (rst || flush) begin
         sbq.delete();
      end else begin
         deq = stall ? 0 : ((sbq.size() < OUT_WIDTH) ? sbq.size() : OUT_WIDTH);
         if (in_en != '0 && !mfull) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
               if (in_en[i]) begin
                  e.inst = in_inst[i*INST_WIDTH +: INST_WIDTH];
                  e.fsq  = in_fsqIdx;
                  e.off  = OFF_W'(i);
                  sbq.push_back(e);
               end
            end
         end
         repeat (deq) void'(sbq.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive_write(8'hFF, 32'hDEAD_0000, 6'd1);
      apply();
      checking = 1'b1;
      apply();
      rst = 1'b0;
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd0 || full !== 1'b0 || out_en !== 4'b0000) begin
         errors++;
         $display("FAIL reset: got count=%0d full=%0b out_en=%b expected 0 0 0000", count, full, out_en);
      end
      apply();
   endtask

   task automatic test_compaction();
      int lanes[4] = '{0, 2, 4, 5};
      stall = 1'b1;
      drive_write(8'b1011_0101, 32'h100, 6'd3);
      apply();
      drive_idle();
      stall = 1'b0;
      #2;
      vectors++;
      if (count !== 6'd5 || out_en !== 4'b1111) begin
         errors++;
         $display("FAIL compact_count: got count=%0d out_en=%b expected 5 1111", count, out_en);
      end
      for (int i = 0; i < OUT_WIDTH; i++) begin
         vectors++;
         if (out_inst[i*INST_WIDTH +: INST_WIDTH] !== 32'h100 + 32'(lanes[i]) ||
             out_offset[i*OFF_W +: OFF_W] !== OFF_W'(lanes[i]) ||
             out_fsqIdx[i*FSQ_W +: FSQ_W] !== 6'd3) begin
            errors++;
            $display("FAIL compact_lane[%0d]: got inst=%h off=%0d fsq=%0d expected inst=%h off=%0d fsq=3",
                     i, out_inst[i*INST_WIDTH +: INST_WIDTH], out_offset[i*OFF_W +: OFF_W],
                     out_fsqIdx[i*FSQ_W +: FSQ_W], 32'h100 + 32'(lanes[i]), lanes[i]);
         end
      end
      apply();
   endtask

   task automatic test_dequeue();
      stall = 1'b0;
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd1 || out_en !== 4'b0001 ||
          out_inst[31:0] !== 32'h107 || out_offset[2:0] !== 3'd7) begin
         errors++;
         $display("FAIL dequeue_tail: got count=%0d out_en=%b inst=%h off=%0d expected 1 0001 107 7",
                  count, out_en, out_inst[31:0], out_offset[2:0]);
      end
      apply();
   endtask

   task automatic test_full();
      stall = 1'b1;
      for (int w = 0; w < 4; w++) begin
         drive_write(8'hFF, 32'h2000 + 32'(w*16), 6'(w));
         apply();
      end
      drive_write(8'hFF, 32'h3000, 6'd9);
      #2;
      vectors++;
      if (count !== 6'd32 || full !== 1'b1) begin
         errors++;
         $display("FAIL full_set: got count=%0d full=%0b expected 32 1", count, full);
      end
      apply();
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd32) begin
         errors++;
         $display("FAIL full_ignore: got count=%0d expected 32", count);
      end
      stall = 1'b0;
      apply();
      apply();
      #2;
      vectors++;
      if (count !== 6'd24 || full !== 1'b0) begin
         errors++;
         $display("FAIL full_release: got count=%0d full=%0b expected 24 0", count, full);
      end
      repeat (6) apply();
      vectors++;
      if (count !== 6'd0) begin
         errors++;
         $display("FAIL full_drain: got count=%0d expected 0", count);
      end
   endtask

   task automatic test_wrap_random();
      logic [IN_WIDTH-1:0] mask;
      for (int c = 0; c < 200; c++) begin
         mask = IN_WIDTH'($urandom);
         if (c % 10 == 0) begin
            mask  = 8'b1110_1101;
            stall = 1'b0;
         end else begin
            stall = ($urandom_range(0, 3) == 0);
         end
         drive_write(mask, $urandom, FSQ_W'($urandom));
         apply();
      end
      drive_idle();
      stall = 1'b0;
      repeat (10) apply();
      vectors++;
      if (count !== 6'd0) begin
         errors++;
         $display("FAIL wrap_drain: got count=%0d expected 0", count);
      end
   endtask

   task automatic test_flush();
      stall = 1'b1;
      drive_write(8'hFF, 32'h4000, 6'd4);
      apply();
      drive_write(8'h0F, 32'h4100, 6'd5);
      apply();
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd12) begin
         errors++;
         $display("FAIL flush_setup: got count=%0d expected 12", count);
      end
      flush = 1'b1;
      stall = 1'b0;
      drive_write(8'hFF, 32'h5000, 6'd6);
      apply();
      flush = 1'b0;
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd0 || out_en !== 4'b0000 || full !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: got count=%0d out_en=%b full=%0b expected 0 0000 0", count, out_en, full);
      end
      drive_write(8'b0010_0000, 32'hABB, 6'd9);
      apply();
      drive_idle();
      #2;
      vectors++;
      if (out_en !== 4'b0001 || out_inst[31:0] !== 32'hAC0 ||
          out_offset[2:0] !== 3'd5 || out_fsqIdx[5:0] !== 6'd9) begin
         errors++;
         $display("FAIL flush_refill: got out_en=%b inst=%h off=%0d fsq=%0d expected 0001 ac0 5 9",
                  out_en, out_inst[31:0], out_offset[2:0], out_fsqIdx[5:0]);
      end
      apply();
   endtask

   task automatic test_reset_mid();
      stall = 1'b1;
      drive_write(8'hFF, 32'h6000, 6'd7);
      apply();
      rst   = 1'b1;
      flush = 1'b1;
      stall = 1'b0;
      drive_write(8'hFF, 32'h7000, 6'd8);
      apply();
      rst   = 1'b0;
      flush = 1'b0;
      drive_idle();
      #2;
      vectors++;
      if (count !== 6'd0 || out_en !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid: got count=%0d out_en=%b expected 0 0000", count, out_en);
      end
      apply();
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      in_en = '0; in_num = '0; in_inst = '0; in_fsqIdx = '0;
      test_reset();
      test_compaction();
      test_dequeue();
      test_full();
      test_wrap_random();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
